// File: rtl/cmp_pipe_unit.sv
// Pipelined compare / branch-condition unit: computes A-B flags, evaluates one of
// eight relations, and keeps the flags of the last retired compare for branching.
module cmp_pipe_unit #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [2:0]       cmp_op,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v,
  output logic             flag_c,
  output logic             cc_z,
  output logic             cc_n,
  output logic             cc_v,
  output logic             cc_c
);

  typedef enum logic [2:0] {
    OP_EQ   = 3'b000,
    OP_NE   = 3'b001,
    OP_LT   = 3'b010,
    OP_LTE  = 3'b011,
    OP_LTU  = 3'b100,
    OP_LTEU = 3'b101,
    OP_GTE  = 3'b110,
    OP_GT   = 3'b111
  } cmp_op_e;

  typedef struct packed {
    logic result;
    logic z;
    logic n;
    logic v;
    logic c;
  } cmp_res_t;

  logic [WIDTH:0] diff;
  logic           signed_lt;
  cmp_res_t       calc;

  // A - B as A + ~B + 1; the carry out is the "no borrow" flag.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    calc      = '0;
    diff      = {1'b0, op_a} + {1'b0, ~op_b} + (WIDTH+1)'(1);
    calc.z    = (diff[WIDTH-1:0] == '0);
    calc.n    = diff[WIDTH-1];
    calc.v    = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
    calc.c    = diff[WIDTH];
    signed_lt = calc.n ^ calc.v;
    unique case (cmp_op_e'(cmp_op))
      OP_EQ:   calc.result = calc.z;
      OP_NE:   calc.result = ~calc.z;
      OP_LT:   calc.result = signed_lt;
      OP_LTE:  calc.result = signed_lt | calc.z;
      OP_LTU:  calc.result = ~calc.c;
      OP_LTEU: calc.result = ~calc.c | calc.z;
      OP_GTE:  calc.result = ~signed_lt;
      OP_GT:   calc.result = ~signed_lt & ~calc.z;
      default: calc.result = 1'b0;
    endcase
  end

  logic     [STAGES-1:0] valid_q, valid_d;
  cmp_res_t [STAGES-1:0] data_q, data_d;
  logic     [STAGES:0]   ready_chain;
  logic     [STAGES-1:0] feed_valid;
  cmp_res_t [STAGES-1:0] feed_data;
  logic     [3:0]        cc_q, cc_d;
  logic                  out_fire;

  // Stage i loads when empty or when stage i+1 (or the consumer) takes its
  // content this cycle; the ready chain runs back from out_ready to in_ready.
  always_comb begin
    ready_chain         = '0;
    feed_valid          = '0;
    feed_data           = '0;
    valid_d             = valid_q;
    data_d              = data_q;
    ready_chain[STAGES] = out_ready;
    feed_valid[0]       = in_valid;
    feed_data[0]        = calc;
    for (int i = 1; i < STAGES; i++) begin
      feed_valid[i] = valid_q[i-1];
      feed_data[i]  = data_q[i-1];
    end
    for (int i = STAGES - 1; i >= 0; i--) begin
      ready_chain[i] = ~valid_q[i] | ready_chain[i+1];
    end
    for (int i = 0; i < STAGES; i++) begin
      if (flush) begin
        valid_d[i] = 1'b0;
      end else if (ready_chain[i]) begin
        valid_d[i] = feed_valid[i];
      end
      if (ready_chain[i] && feed_valid[i]) begin
        data_d[i] = feed_data[i];
      end
    end
  end

  assign out_fire = valid_q[STAGES-1] & out_ready;

  always_comb begin
    cc_d = cc_q;
    if (out_fire) begin
      cc_d = {data_q[STAGES-1].z, data_q[STAGES-1].n, data_q[STAGES-1].v, data_q[STAGES-1].c};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: stage data is reset along with the valid bits because result and
      // flag outputs must read 0 out of reset, not merely be marked invalid.
      valid_q <= '0;
      data_q  <= '0;
      cc_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every stage samples the pre-edge value of its neighbour.
      valid_q <= valid_d;
      data_q  <= data_d;
      cc_q    <= cc_d;
    end
  end

  assign in_ready  = ready_chain[0];
  assign out_valid = valid_q[STAGES-1];
  assign result    = data_q[STAGES-1].result;
  assign flag_z    = data_q[STAGES-1].z;
  assign flag_n    = data_q[STAGES-1].n;
  assign flag_v    = data_q[STAGES-1].v;
  assign flag_c    = data_q[STAGES-1].c;
  assign {cc_z, cc_n, cc_v, cc_c} = cc_q;

endmodule

// File: tb/tb_cmp_pipe_unit.sv
// Scoreboard bench for cmp_pipe_unit: one instance with STAGES=1, one with STAGES=2.
module tb_cmp_pipe_unit;

  localparam logic [2:0] EQ = 3'd0, NE = 3'd1, LT = 3'd2, LTE = 3'd3;
  localparam logic [2:0] LTU = 3'd4, LTEU = 3'd5, GTE = 3'd6, GT = 3'd7;

  logic        clk, rst_n;
  logic        iv1, fl1, or1, iv2, fl2, or2;
  logic [15:0] a1, b1, a2, b2;
  logic [2:0]  op1, op2;
  logic [4:0]  exp1, exp2;
  wire         ir1, ov1, res1, ir2, ov2, res2;
  wire  [3:0]  flg1, cc1, flg2, cc2;

  logic [4:0]  q1[$], q2[$];
  int          n_checks, n_pass, ret1, ret2, cyc, first_cyc2, last_cyc2;

  cmp_pipe_unit #(.WIDTH(16), .STAGES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .op_a(a1), .op_b(b1),
    .cmp_op(op1), .flush(fl1), .out_valid(ov1), .out_ready(or1), .result(res1),
    .flag_z(flg1[3]), .flag_n(flg1[2]), .flag_v(flg1[1]), .flag_c(flg1[0]),
    .cc_z(cc1[3]), .cc_n(cc1[2]), .cc_v(cc1[1]), .cc_c(cc1[0])
  );

  cmp_pipe_unit #(.WIDTH(16), .STAGES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .op_a(a2), .op_b(b2),
    .cmp_op(op2), .flush(fl2), .out_valid(ov2), .out_ready(or2), .result(res2),
    .flag_z(flg2[3]), .flag_n(flg2[2]), .flag_v(flg2[1]), .flag_c(flg2[0]),
    .cc_z(cc2[3]), .cc_n(cc2[2]), .cc_v(cc2[1]), .cc_c(cc2[0])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else n_pass++;
  endfunction

  // Expected entries are pushed on accept, popped on retire; a flush drops what stays in flight.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ov1 && or1) begin
        if (q1.size() == 0) check("dut1_extra_out", 32'(q1.size()), 1);
        else check("dut1_out", {27'b0, res1, flg1}, {27'b0, q1.pop_front()});
        ret1++;
      end
      if (fl1) q1.delete();
      else if (iv1 && ir1) q1.push_back(exp1);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (ov2 && or2) begin
        if (q2.size() == 0) check("dut2_extra_out", 32'(q2.size()), 1);
        else check("dut2_out", {27'b0, res2, flg2}, {27'b0, q2.pop_front()});
        if (ret2 == 0) first_cyc2 = cyc;
        last_cyc2 = cyc;
        ret2++;
      end
      if (fl2) q2.delete();
      else if (iv2 && ir2) q2.push_back(exp2);
    end
  end

  task automatic send1(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                       input logic [4:0] e);
    int n = 0;
    a1 = a; b1 = b; op1 = op; exp1 = e; iv1 = 1'b1;
    @(negedge clk);
    while (!ir1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("dut1_send_timeout", 32'(ir1), 1);
    @(posedge clk);
    #1;
  endtask

  logic [15:0] va2 [5] = '{16'h0003, 16'h8000, 16'h0000, 16'hFFFF, 16'h1234};
  logic [15:0] vb2 [5] = '{16'h0007, 16'h7FFF, 16'hFFFF, 16'h0001, 16'h1235};
  logic [2:0]  vo2 [5] = '{GTE, GT, LTU, LTEU, NE};
  logic [4:0]  ve2 [5] = '{5'b0_0100, 5'b0_0011, 5'b1_0000, 5'b0_0101, 5'b1_0100};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0; n_pass = 0; ret1 = 0; ret2 = 0; first_cyc2 = 0; last_cyc2 = 0;
    rst_n = 1'b0;
    {iv1, fl1, or1, iv2, fl2, or2} = '0;
    {a1, b1, a2, b2} = '0;
    {op1, op2, exp1, exp2} = '0;
    repeat (2) @(negedge clk);
    check("rst_dut1_out", {24'b0, ov1, res1, flg1, cc1[1:0]}, 0);
    check("rst_dut1_cc", {28'b0, cc1}, 0);
    check("rst_dut2_out", {21'b0, ov2, res2, flg2, cc2}, 0);
    check("rst_in_ready", {30'b0, ir1, ir2}, 32'h3);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Signed overflow case and equal operands, full throughput
    or1 = 1'b1;
    send1(16'h7FFF, 16'h8000, LT,  5'b0_0110);
    send1(16'h7FFF, 16'h8000, LTU, 5'b1_0110);
    send1(16'h7FFF, 16'h8000, GT,  5'b1_0110);
    send1(16'h0005, 16'h0005, LTE, 5'b1_1001);
    send1(16'h0005, 16'h0005, LT,  5'b0_1001);
    send1(16'h0005, 16'h0005, EQ,  5'b1_1001);
    iv1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("cc_after_eq", {28'b0, cc1}, 32'h9);

    // Backpressure: consumer stalls for 3 cycles
    or1 = 1'b0;
    fork
      begin
        repeat (3) @(posedge clk);
        #1 or1 = 1'b1;
      end
    join_none
    send1(16'h0001, 16'h0002, LTU, 5'b1_0100);
    check("bp_in_ready_low", {31'b0, ir1}, 0);
    check("bp_out_held", {31'b0, ov1}, 1);
    send1(16'h0002, 16'h0002, LTU, 5'b0_1001);
    send1(16'h0003, 16'h0002, LTU, 5'b0_0001);
    send1(16'h0004, 16'h0002, LTU, 5'b0_0001);
    iv1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("dut1_drain", 32'(q1.size()), 0);
    check("dut1_retired", 32'(ret1), 10);

    // Flush with a stalled output: result dropped, cc unchanged
    or1 = 1'b0;
    send1(16'h8000, 16'h0001, LT, 5'b1_0011);
    iv1 = 1'b0;
    fl1 = 1'b1;
    check("flush_pre_valid", {31'b0, ov1}, 1);
    @(posedge clk);
    #1;
    fl1 = 1'b0;
    check("flush_valid_cleared", {31'b0, ov1}, 0);
    check("flush_cc_hold", {28'b0, cc1}, 32'h1);

    // Flush together with an output transfer and a discarded input transfer
    send1(16'h0003, 16'h0007, GTE, 5'b0_0100);
    or1 = 1'b1; fl1 = 1'b1;
    a1 = 16'h0005; b1 = 16'h0005; op1 = EQ; exp1 = 5'b1_1001; iv1 = 1'b1;
    @(posedge clk);
    #1;
    fl1 = 1'b0; iv1 = 1'b0;
    check("flush_discard_in", {31'b0, ov1}, 0);
    check("flush_cc_update", {28'b0, cc1}, 32'h4);
    check("dut1_retired_flush", 32'(ret1), 11);

    // STAGES=2: two-cycle latency then one result per cycle
    or2 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a2 = va2[i]; b2 = vb2[i]; op2 = vo2[i]; exp2 = ve2[i]; iv2 = 1'b1;
      @(negedge clk);
      check("dut2_in_ready", {31'b0, ir2}, 1);
      @(posedge clk);
      #1;
      if (i == 0) check("dut2_lat_not_yet", {31'b0, ov2}, 0);
      if (i == 1) check("dut2_lat_two", {31'b0, ov2}, 1);
    end
    iv2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("dut2_drain", 32'(q2.size()), 0);
    check("dut2_retired", 32'(ret2), 5);
    check("dut2_throughput", 32'(last_cyc2 - first_cyc2), 4);
    check("dut2_cc", {28'b0, cc2}, 32'h4);

    // Reset while the STAGES=2 pipe holds two results
    or2 = 1'b0;
    a2 = va2[0]; b2 = vb2[0]; op2 = vo2[0]; exp2 = ve2[0]; iv2 = 1'b1;
    @(posedge clk);
    #1;
    a2 = va2[1]; b2 = vb2[1]; op2 = vo2[1]; exp2 = ve2[1];
    @(posedge clk);
    #1;
    iv2 = 1'b0;
    check("pre_rst_valid", {31'b0, ov2}, 1);
    #1 rst_n = 1'b0;
    #1;
    q1.delete();
    q2.delete();
    check("mid_rst_dut2_out", {21'b0, ov2, res2, flg2, cc2}, 0);
    check("mid_rst_dut1_cc", {28'b0, cc1}, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", {30'b0, ir1, ir2}, 32'h3);
    check("post_rst_empty", {31'b0, ov2}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cmp_pipe_unit.md
Name: cmp_pipe_unit

Overview:
- Parametrised, pipelined compare/branch-condition unit for the execute stage.
- Computes A−B at WIDTH bits and derives Z/N/V/C flags.
- Evaluates one of eight signed/unsigned relations per transaction, with valid/ready handshakes on both sides and a programmable pipeline depth.
- Holds the flags of the last retired compare in a condition-code register for the branch unit.

Parameters:
- WIDTH, 16, operand width in bits (≥2).
- STAGES, 1, pipeline register stages between input and output (legal values 1 or 2).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand set valid.
- in_ready  output  1  unit accepts operands this cycle.
- op_a  input  WIDTH  operand A.
- op_b  input  WIDTH  operand B.
- cmp_op  input  3  relation select.
- flush  input  1  synchronous pipeline kill.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  1  relation outcome.
- flag_z, flag_n, flag_v, flag_c  output  1 each  flags of the transaction at the output.
- cc_z, cc_n, cc_v, cc_c  output  1 each  sticky condition codes of the last retired transaction.

Behaviour:
- Arithmetic:
  - {c,d} = {1'b0,op_a} + {1'b0,~op_b} + 1, d is WIDTH bits.
  - Z = (d==0).
  - N = d[WIDTH-1].
  - V = (op_a[MSB]≠op_b[MSB]) & (d[MSB]≠op_a[MSB]).
  - C = c; C=1 means no borrow.
- cmp_op encoding:
  - 000 EQ = Z.
  - 001 NE = ~Z.
  - 010 LT = N^V.
  - 011 LTE = (N^V)|Z.
  - 100 LTU = ~C.
  - 101 LTEU = ~C|Z.
  - 110 GTE = ~(N^V).
  - 111 GT = ~(N^V)&~Z.
  - All codes legal.
- Computation:
  - Flags and result are computed in stage 1 from registered-in operands and stored in stage registers.
  - With STAGES=2, stage 2 is a plain pipeline copy.
- Latency: accepted at edge k → out_valid high after edge k+STAGES−1 of the same handshake chain, i.e. visible STAGES cycles after the accept when unstalled.
- Handshake:
  - Transfer in on in_valid&in_ready; transfer out on out_valid&out_ready.
  - Each stage has a valid bit.
  - A stage loads when it is empty or its downstream transfers in the same cycle.
  - in_ready = ~v1 | (stage1 advances this cycle); it is combinational from out_ready through the stage chain.
  - Full throughput: one transaction per cycle when out_ready=1.
  - out_valid, result and flag_* stay stable while out_valid&~out_ready.
  - Order is preserved; no drop, no duplicate.
- Condition codes: on each out transfer, cc_* ← flag_*. They hold otherwise and are unaffected by flush.
- Flush:
  - Clears all stage valid bits on the next edge.
  - An input transfer in the same cycle is discarded; in_ready is still driven normally.
  - An output transfer in the same cycle completes, and cc updates.
- Reset:
  - Asynchronous; all valid bits, result, flag_* and cc_* go to 0, so in_ready=1 after release.
  - Reset mid-transaction discards in-flight data.
- Simultaneous full pipe plus out transfer plus in transfer: the pipe shifts and stays full, with no bubble.

Test Plan:
- WIDTH=16, STAGES=1, a=0x7FFF, b=0x8000:
  - op 010 → result 0, V=1, N=1, Z=0.
  - op 100 → result 1 (C=0).
  - op 111 → result 1.
- a=0x0005, b=0x0005:
  - op 011 → 1.
  - op 010 → 0.
  - op 000 → 1, with Z=1, C=1.
  - Retire → cc_z=1, cc_c=1.
- Backpressure:
  - Stream 4 ops (a=1..4, b=2, op 100) with out_ready=0 for 3 cycles.
  - in_ready drops once the pipe fills; results emerge in order 1,0,0,0; nothing is lost.
- Flush:
  - Issue a=0x8000, b=0x0001, op 010, then assert flush the cycle after the accept with out_ready=0.
  - out_valid=0 next cycle; cc_* keep their prior values.
- STAGES=2, out_ready=1, back-to-back ops:
  - First result appears 2 cycles after the accept, then one per cycle.
  - Deassert rst_n mid-stream → all outputs 0 immediately, in_ready=1 after release.
